// File: rtl/match_pkg.sv
// match_pkg: phase encoding, winner codes and kickoff-side codes shared by the match sequencer
package match_pkg;
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      KICKOFF    = 3'd1,
      PLAY       = 3'd2,
      GOAL_PAUSE = 3'd3,
      HALFTIME   = 3'd4,
      FULLTIME   = 3'd5
   } phase_t;
   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_T1   = 2'b01;
   localparam logic [1:0] WIN_T2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;
   localparam logic KICK_T1 = 1'b0;
   localparam logic KICK_T2 = 1'b1;
   function automatic logic [1:0] winner_of(input logic [7:0] s1, input logic [7:0] s2);
      return s1 > s2 ? WIN_T1 : s1 < s2 ? WIN_T2 : WIN_DRAW;
   endfunction
endpackage

// File: rtl/match_controller_second_ticker.sv
// second_ticker: one-cycle tick every CLK_HZ cycles, restartable so phases last whole seconds
module second_ticker #(
   parameter int CLK_HZ = 50000000
) (
   input  logic Clk,
   input  logic Reset,
   input  logic clear,
   output logic tick
);
   localparam int W = $clog2(CLK_HZ);
   logic [W-1:0] cnt_q;
   assign tick = cnt_q == W'(CLK_HZ - 1);
   // prescaler wraps at CLK_HZ-1 and restarts from zero whenever the phase changes
   always_ff @(posedge Clk) begin
      if (Reset || clear || tick) cnt_q <= '0;
      else cnt_q <= cnt_q + 1'b1;
   end
endmodule

// File: rtl/match_controller.sv
// match_controller: match sequencer driving kickoff, halves, goal pauses, mercy stop and full time
module match_controller
   import match_pkg::*;
#(
   parameter int CLK_HZ             = 50000000,
   parameter int HALF_SECONDS       = 90,
   parameter int KICKOFF_SECONDS    = 3,
   parameter int GOAL_PAUSE_SECONDS = 2,
   parameter int WIN_GOALS          = 5
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       start,
   input  logic       goal1,
   input  logic       goal2,
   input  logic [7:0] score1,
   input  logic [7:0] score2,
   output logic       freeze,
   output logic       resetfieldsig,
   output logic       score_clear,
   output logic [2:0] phase,
   output logic       half,
   output logic [6:0] time_left,
   output logic       kickoff_side,
   output logic       match_over,
   output logic [1:0] winner
);
   phase_t     state_q, state_d;
   logic       half_q, half_d;
   logic [6:0] time_q, time_d;
   logic       kick_q, kick_d;
   logic [1:0] win_q, win_d;
   logic [7:0] sec_q, sec_d;
   logic       tick, clear;
   second_ticker #(.CLK_HZ(CLK_HZ)) u_ticker (
      .Clk  (Clk),
      .Reset(Reset),
      .clear(clear),
      .tick (tick)
   );
   assign phase         = state_q;
   assign half          = half_q;
   assign time_left     = time_q;
   assign kickoff_side  = kick_q;
   assign winner        = win_q;
   assign freeze        = state_q != PLAY;
   assign resetfieldsig = state_q == KICKOFF;
   assign match_over    = state_q == FULLTIME;
   assign score_clear   = start && (state_q == IDLE || state_q == FULLTIME);
   // next phase and match registers; sec counts whole seconds spent in the current phase
   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      time_d  = time_q;
      kick_d  = kick_q;
      win_d   = win_q;
      sec_d   = tick ? sec_q + 8'd1 : sec_q;
      case (state_q)
         IDLE, FULLTIME: if (start) begin
            state_d = KICKOFF;
            half_d  = 1'b0;
            time_d  = 7'(HALF_SECONDS);
            kick_d  = KICK_T1;
            win_d   = WIN_NONE;
         end
         KICKOFF: if (tick && sec_q == 8'(KICKOFF_SECONDS - 1)) state_d = PLAY;
         PLAY: if (goal1 || goal2) begin
            state_d = GOAL_PAUSE;
            kick_d  = goal1 ? KICK_T2 : KICK_T1;
         end else if (tick && time_q != 7'd0) begin
            time_d = time_q - 7'd1;
            if (time_q == 7'd1) begin
               state_d = half_q ? FULLTIME : HALFTIME;
               win_d   = half_q ? winner_of(score1, score2) : win_q;
            end
         end
         GOAL_PAUSE: if (tick && sec_q == 8'(GOAL_PAUSE_SECONDS - 1)) begin
            if (score1 >= 8'(WIN_GOALS) || score2 >= 8'(WIN_GOALS)) begin
               state_d = FULLTIME;
               win_d   = winner_of(score1, score2);
            end else state_d = KICKOFF;
         end
         HALFTIME: if (start) begin
            state_d = KICKOFF;
            half_d  = 1'b1;
            time_d  = 7'(HALF_SECONDS);
            kick_d  = KICK_T2;
         end
         default: state_d = IDLE;
      endcase
      clear = state_d != state_q;
      if (clear) sec_d = 8'd0;
   end
   // state and match registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         half_q  <= 1'b0;
         time_q  <= 7'(HALF_SECONDS);
         kick_q  <= KICK_T1;
         win_q   <= WIN_NONE;
         sec_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         half_q  <= half_d;
         time_q  <= time_d;
         kick_q  <= kick_d;
         win_q   <= win_d;
         sec_q   <= sec_d;
      end
   end
endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: directed match scenarios plus randomized play against a cycle-count model
module tb_match_controller;
   localparam int CLK = 4, HALF = 5, KO = 2, GP = 1, WIN = 3;
   logic clk = 0, rst = 0, start = 0, goal1 = 0, goal2 = 0;
   logic [7:0] score1 = 0, score2 = 0;
   logic freeze, resetfieldsig, score_clear, half, kickoff_side, match_over;
   logic [2:0] phase;
   logic [6:0] time_left;
   logic [1:0] winner;
   int checks = 0, passes = 0;
   int m_phase = 0, m_cnt = 0, m_tl = HALF;
   logic m_half = 0, m_ks = 0;
   logic [1:0] m_win = 0;

   match_controller #(.CLK_HZ(CLK), .HALF_SECONDS(HALF), .KICKOFF_SECONDS(KO),
      .GOAL_PAUSE_SECONDS(GP), .WIN_GOALS(WIN)) dut (
      .Clk(clk), .Reset(rst), .start(start), .goal1(goal1), .goal2(goal2),
      .score1(score1), .score2(score2), .freeze(freeze), .resetfieldsig(resetfieldsig),
      .score_clear(score_clear), .phase(phase), .half(half), .time_left(time_left),
      .kickoff_side(kickoff_side), .match_over(match_over), .winner(winner));

   always #5 clk = ~clk;

   function automatic logic [1:0] m_winner();
      return score1 > score2 ? 2'b01 : score1 < score2 ? 2'b10 : 2'b11;
   endfunction

   // model: a phase lasts a whole number of CLK-cycle seconds counted from its entry cycle
   task automatic m_step();
      int np;
      np = m_phase;
      if (rst) begin
         m_phase = 0; m_half = 0; m_tl = HALF; m_ks = 0; m_win = 0; m_cnt = 0;
         return;
      end
      case (m_phase)
         0, 5: if (start) begin np = 1; m_half = 0; m_tl = HALF; m_ks = 0; m_win = 0; end
         1: if (m_cnt + 1 == KO * CLK) np = 2;
         2: if (goal1 || goal2) begin
               np = 3; m_ks = goal1;
            end else if ((m_cnt + 1) % CLK == 0) begin
               m_tl--;
               if (m_tl == 0) begin np = m_half ? 5 : 4; if (m_half) m_win = m_winner(); end
            end
         3: if (m_cnt + 1 == GP * CLK) begin
               if (score1 >= WIN || score2 >= WIN) begin np = 5; m_win = m_winner(); end
               else np = 1;
            end
         4: if (start) begin np = 1; m_half = 1; m_tl = HALF; m_ks = 1; end
         default: ;
      endcase
      m_cnt = (np != m_phase) ? 0 : m_cnt + 1;
      m_phase = np;
   endtask

   task automatic cyc();
      m_step();
      @(posedge clk); #1;
      start = 0; goal1 = 0; goal2 = 0;
   endtask

   task automatic test_reset();
      rst = 1; cyc(); rst = 0;
      checks++;
      if ({phase, half, time_left, kickoff_side, winner} !== {3'd0, 1'b0, 7'd5, 1'b0, 2'b00})
         $display("FAIL reset_regs got %h want %h", {phase, half, time_left, kickoff_side, winner}, {3'd0, 1'b0, 7'd5, 1'b0, 2'b00});
      else passes++;
      checks++;
      if ({freeze, resetfieldsig, score_clear, match_over} !== 4'b1000)
         $display("FAIL reset_outs got %b want 1000", {freeze, resetfieldsig, score_clear, match_over});
      else passes++;
   endtask

   task automatic test_kickoff();
      start = 1; #1;
      checks++;
      if (score_clear !== 1'b1) $display("FAIL start_clear got %b want 1", score_clear); else passes++;
      cyc();
      checks++;
      if (score_clear !== 1'b0) $display("FAIL clear_width got %b want 0", score_clear); else passes++;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({phase, freeze, resetfieldsig} !== {3'd1, 2'b11})
            $display("FAIL kickoff_hold cyc %0d got %b want 00111", i, {phase, freeze, resetfieldsig});
         else passes++;
         cyc();
      end
      checks++;
      if ({phase, freeze, time_left} !== {3'd2, 1'b0, 7'd5})
         $display("FAIL play_entry got %h want %h", {phase, freeze, time_left}, {3'd2, 1'b0, 7'd5});
      else passes++;
   endtask

   task automatic test_first_half();
      for (int s = 5; s >= 1; s--)
         for (int c = 0; c < 4; c++) begin
            checks++;
            if ({phase, time_left} !== {3'd2, 7'(s)})
               $display("FAIL half1_count got p%0d t%0d want p2 t%0d", phase, time_left, s);
            else passes++;
            cyc();
         end
      checks++;
      if ({phase, time_left} !== {3'd4, 7'd0}) $display("FAIL halftime got p%0d t%0d want p4 t0", phase, time_left); else passes++;
      start = 1; #1;
      checks++;
      if (score_clear !== 1'b0) $display("FAIL ht_no_clear got %b want 0", score_clear); else passes++;
      cyc();
      checks++;
      if ({phase, half, time_left, kickoff_side} !== {3'd1, 1'b1, 7'd5, 1'b1})
         $display("FAIL second_half got %h want %h", {phase, half, time_left, kickoff_side}, {3'd1, 1'b1, 7'd5, 1'b1});
      else passes++;
      repeat (8) cyc();
   endtask

   task automatic test_goal_pause();
      score1 = 1; score2 = 0;
      repeat (8) cyc();
      checks++;
      if (time_left !== 7'd3) $display("FAIL pre_goal_time got %0d want 3", time_left); else passes++;
      goal1 = 1; cyc();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({phase, time_left, kickoff_side} !== {3'd3, 7'd3, 1'b1})
            $display("FAIL pause_hold cyc %0d got p%0d t%0d k%0d want p3 t3 k1", i, phase, time_left, kickoff_side);
         else passes++;
         cyc();
      end
      checks++;
      if (phase !== 3'd1) $display("FAIL pause_to_kickoff got %0d want 1", phase); else passes++;
      repeat (8) cyc();
      checks++;
      if ({phase, time_left} !== {3'd2, 7'd3}) $display("FAIL resume_play got p%0d t%0d want p2 t3", phase, time_left); else passes++;
   endtask

   task automatic test_final_tick_goal();
      score2 = 1;
      repeat (11) cyc();
      checks++;
      if (time_left !== 7'd1) $display("FAIL last_second got %0d want 1", time_left); else passes++;
      goal2 = 1; cyc();
      checks++;
      if ({phase, time_left, kickoff_side} !== {3'd3, 7'd1, 1'b0})
         $display("FAIL goal_beats_tick got p%0d t%0d k%0d want p3 t1 k0", phase, time_left, kickoff_side);
      else passes++;
      repeat (4) cyc();
      checks++;
      if (phase !== 3'd1) $display("FAIL ftg_kickoff got %0d want 1", phase); else passes++;
      repeat (8) cyc();
      checks++;
      if ({phase, time_left} !== {3'd2, 7'd1}) $display("FAIL ftg_play got p%0d t%0d want p2 t1", phase, time_left); else passes++;
      repeat (4) cyc();
      checks++;
      if ({phase, time_left, match_over, winner} !== {3'd5, 7'd0, 1'b1, 2'b11})
         $display("FAIL fulltime_draw got p%0d t%0d m%b w%b want p5 t0 m1 w11", phase, time_left, match_over, winner);
      else passes++;
   endtask

   task automatic test_mercy();
      start = 1; #1;
      checks++;
      if (score_clear !== 1'b1) $display("FAIL restart_clear got %b want 1", score_clear); else passes++;
      cyc();
      score1 = 0; score2 = 0;
      checks++;
      if ({phase, half, time_left, winner} !== {3'd1, 1'b0, 7'd5, 2'b00})
         $display("FAIL restart_regs got %h want %h", {phase, half, time_left, winner}, {3'd1, 1'b0, 7'd5, 2'b00});
      else passes++;
      repeat (12) cyc();
      goal1 = 1; cyc();
      score1 = 3;
      checks++;
      if ({phase, time_left} !== {3'd3, 7'd4}) $display("FAIL mercy_pause got p%0d t%0d want p3 t4", phase, time_left); else passes++;
      repeat (4) cyc();
      checks++;
      if ({phase, match_over, winner} !== {3'd5, 1'b1, 2'b01})
         $display("FAIL mercy_end got p%0d m%b w%b want p5 m1 w01", phase, match_over, winner);
      else passes++;
      start = 1; #1;
      checks++;
      if (score_clear !== 1'b1) $display("FAIL ft_clear got %b want 1", score_clear); else passes++;
      cyc();
      score1 = 0;
      checks++;
      if ({phase, half, time_left} !== {3'd1, 1'b0, 7'd5}) $display("FAIL ft_restart got p%0d h%b t%0d want p1 h0 t5", phase, half, time_left); else passes++;
   endtask

   task automatic test_reset_and_ignored();
      repeat (8) cyc();
      goal2 = 1; cyc(); cyc();
      rst = 1; cyc(); rst = 0;
      checks++;
      if ({phase, half, time_left, kickoff_side, winner, freeze} !== {3'd0, 1'b0, 7'd5, 1'b0, 2'b00, 1'b1})
         $display("FAIL mid_pause_reset got %h want %h", {phase, half, time_left, kickoff_side, winner, freeze}, {3'd0, 1'b0, 7'd5, 1'b0, 2'b00, 1'b1});
      else passes++;
      goal1 = 1; cyc();
      checks++;
      if ({phase, kickoff_side, time_left} !== {3'd0, 1'b0, 7'd5}) $display("FAIL idle_goal got p%0d k%0d t%0d want p0 k0 t5", phase, kickoff_side, time_left); else passes++;
      start = 1; cyc();
      repeat (8) cyc();
      start = 1; #1;
      checks++;
      if (score_clear !== 1'b0) $display("FAIL play_start_clear got %b want 0", score_clear); else passes++;
      cyc();
      checks++;
      if ({phase, half, time_left} !== {3'd2, 1'b0, 7'd5}) $display("FAIL play_start got p%0d h%b t%0d want p2 h0 t5", phase, half, time_left); else passes++;
   endtask

   task automatic test_random();
      logic exp_sc, g1, g2, st, r;
      int ps;
      rst = 1; cyc(); rst = 0;
      score1 = 0; score2 = 0;
      for (int i = 0; i < 4000; i++) begin
         rst   = ($urandom_range(999) == 0);
         start = ($urandom_range(15) == 0);
         goal1 = ($urandom_range(63) == 0);
         goal2 = ($urandom_range(63) == 0);
         #1;
         exp_sc = start && (m_phase == 0 || m_phase == 5);
         if (!rst) begin
            checks++;
            if (score_clear !== exp_sc) $display("FAIL rand_clear cyc %0d got %b want %b", i, score_clear, exp_sc); else passes++;
         end
         ps = m_phase; g1 = goal1; g2 = goal2; st = start; r = rst;
         cyc();
         if (r || (st && (ps == 0 || ps == 5))) begin score1 = 0; score2 = 0; end
         else if (ps == 2 && g1) score1++;
         else if (ps == 2 && g2) score2++;
         checks++;
         if ({phase, half, time_left, kickoff_side, winner, freeze, resetfieldsig, match_over} !==
             {3'(m_phase), m_half, 7'(m_tl), m_ks, m_win, m_phase != 2, m_phase == 1, m_phase == 5})
            $display("FAIL rand_state cyc %0d got p%0d h%b t%0d k%b w%b f%b r%b m%b want p%0d h%b t%0d k%b w%b",
               i, phase, half, time_left, kickoff_side, winner, freeze, resetfieldsig, match_over,
               m_phase, m_half, m_tl, m_ks, m_win);
         else passes++;
      end
      rst = 0;
   endtask

   initial begin
      #2;
      test_reset();
      test_kickoff();
      test_first_half();
      test_goal_pause();
      test_final_tick_goal();
      test_mercy();
      test_reset_and_ignored();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
Top-level match sequencer that runs the game around the scoring engine. It handles start-of-match, kickoff countdown, timed halves, the pause after each goal, halftime, a mercy-rule stop and full time. It tells the player/ball logic when to freeze and when to re-centre, and it tells the scoring engine when to clear its scores. It sits between the keypad/start logic, the scoring engine (goal pulses in, scores in) and the motion blocks (freeze and field reset out).

Parameters:
CLK_HZ, 50000000, Clk cycles per match second; minimum 2.
HALF_SECONDS, 90, length of each half in seconds; range 1..127.
KICKOFF_SECONDS, 3, freeze/countdown length before play resumes.
GOAL_PAUSE_SECONDS, 2, freeze length after a goal.
WIN_GOALS, 5, mercy rule: the match ends when either score reaches this value.

Ports:
Clk  in  1  system clock.
Reset  in  1  synchronous, active-high reset.
start  in  1  single-cycle start/continue request.
goal1  in  1  single-cycle pulse: team 1 scored.
goal2  in  1  single-cycle pulse: team 2 scored.
score1  in  8  team 1 score, unsigned binary.
score2  in  8  team 2 score, unsigned binary.
freeze  out  1  halts player and ball motion.
resetfieldsig  out  1  holds ball and players at kickoff positions.
score_clear  out  1  single-cycle pulse that zeroes the scoring engine.
phase  out  3  current phase_t encoding.
half  out  1  0 = first half, 1 = second half.
time_left  out  7  seconds remaining in the current half.
kickoff_side  out  1  0 = team 1 kicks off, 1 = team 2 kicks off.
match_over  out  1  high while in FULLTIME.
winner  out  2  01 = team 1, 10 = team 2, 11 = draw, 00 = undecided.

Behaviour:
- Reset (sampled at the Clk edge) puts the block in IDLE with these register values: half=0, time_left=HALF_SECONDS, kickoff_side=0, winner=00, second prescaler=0.
  - Outputs in IDLE: freeze=1, resetfieldsig=0, score_clear=0, match_over=0.
  - Reset asserted in any state gives exactly this result on the next edge.
- Second tick: the prescaler counts 0..CLK_HZ-1 and emits a one-cycle tick at CLK_HZ-1.
  - The prescaler clears on every state transition, so a phase of N seconds lasts exactly N*CLK_HZ cycles.
- States (phase_t): IDLE=0, KICKOFF=1, PLAY=2, GOAL_PAUSE=3, HALFTIME=4, FULLTIME=5.
- Output decode (registered state, combinational decode):
  - freeze=0 only in PLAY.
  - resetfieldsig=1 only in KICKOFF.
  - match_over=1 only in FULLTIME.
- IDLE:
  - start goes to KICKOFF.
  - score_clear pulses high for the one cycle in which start is accepted.
  - On that cycle: half=0, time_left=HALF_SECONDS, kickoff_side=0, winner=00.
- KICKOFF: after KICKOFF_SECONDS ticks, go to PLAY.
- PLAY:
  - On each tick, time_left decrements.
  - A tick that brings time_left to 0 goes to HALFTIME if half=0, otherwise to FULLTIME.
  - goal1 or goal2 goes to GOAL_PAUSE. On the same edge, kickoff_side is set to the conceding team (goal1 sets 1, goal2 sets 0) and time_left is not decremented that cycle.
  - A goal in the same cycle as the final tick: the goal wins, and time_left stays at 1.
  - goal1 and goal2 in the same cycle: goal1 wins.
- GOAL_PAUSE:
  - time_left is held.
  - After GOAL_PAUSE_SECONDS ticks, sample score1 and score2:
    - If either is >= WIN_GOALS, go to FULLTIME.
    - Otherwise go to KICKOFF.
- HALFTIME: start sets half=1, time_left=HALF_SECONDS and kickoff_side=1, then goes to KICKOFF. score_clear is not pulsed.
- FULLTIME:
  - winner is set on entry from the scores: score1>score2 gives 01, score1<score2 gives 10, equal gives 11. It holds thereafter.
  - start behaves exactly like start in IDLE: score_clear pulse, then KICKOFF.
- Ignored inputs, with no effect:
  - goal pulses in every state except PLAY.
  - start in KICKOFF, PLAY and GOAL_PAUSE.
- Width rules:
  - time_left never underflows; decrement happens only when it is > 0.
  - Score comparisons are unsigned 8-bit.
  - The prescaler width is $clog2(CLK_HZ).

Decomposition:
- Package match_pkg holds:
  - the phase_t enum (3-bit, encodings above);
  - winner constants WIN_NONE, WIN_T1, WIN_T2, WIN_DRAW;
  - the kickoff_side constants.
- One sub-module, second_ticker: parameter CLK_HZ; inputs Clk, Reset, clear; output tick.
- The FSM, time and winner registers stay in match_controller.

Test Plan:
All scenarios use CLK_HZ=4, HALF_SECONDS=5, KICKOFF_SECONDS=2, GOAL_PAUSE_SECONDS=1, WIN_GOALS=3.
1. Reset, then start pulse -> score_clear high exactly 1 cycle; phase=1 with freeze=1 and resetfieldsig=1 for exactly 8 cycles; then phase=2, freeze=0, time_left=5.
2. No goals, first half -> time_left steps 5,4,3,2,1 every 4 cycles; at cycle 20 of PLAY, phase=4. start -> half=1, time_left=5, kickoff_side=1, phase=1, no score_clear.
3. goal1 pulse while time_left=3 -> phase=3 for 4 cycles, time_left stays 3, kickoff_side=1; then phase=1, then phase=2 with time_left=3.
4. Second half, goal2 on the same cycle as the final tick -> phase=3, time_left=1; after the pause, KICKOFF, then PLAY. After 4 more cycles: time_left=0, phase=5, match_over=1, winner per scores (score1=1, score2=1 gives winner=11).
5. score1 driven to 3 during a GOAL_PAUSE with time_left=4 -> phase=5 at pause end, winner=01. start -> score_clear pulse, half=0, time_left=5.
6. Reset mid-GOAL_PAUSE -> next cycle phase=0, all reset values. goal1 in IDLE and start in PLAY -> no state or register change.
